// File: rtl/io_interconnect_pkg.sv
// Shared types and width helpers for the IO interconnect and its round-robin arbiter.
package io_interconnect_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RESPOND = 2'd2
   } io_state_t;

   // Core-index width, never narrower than one bit so a single-core build still has a port.
   function automatic int core_id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/io_interconnect_rr_arbiter.sv
// Round-robin arbiter: one-hot grant of the first request at or after the pointer;
// the pointer moves past the winner only when the caller commits the grant.
module rr_arbiter
   import io_interconnect_pkg::*;
#(
   parameter int  NUM_REQUESTERS = 4,
   localparam int IDX_W          = core_id_width(NUM_REQUESTERS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQUESTERS-1:0] i_req,
   input  logic                      i_update_en,
   output logic [NUM_REQUESTERS-1:0] o_grant,
   output logic [IDX_W-1:0]          o_grant_idx,
   output logic                      o_any
);

   logic [IDX_W-1:0]          r_ptr;
   logic [NUM_REQUESTERS-1:0] w_req_hi;
   logic [NUM_REQUESTERS-1:0] w_req_sel;

   // Requests at or above the pointer take priority; otherwise wrap to the lowest index.
   always_comb begin
      w_req_hi = '0;
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
         w_req_hi[i] = i_req[i] && (i >= int'(r_ptr));
      end
      w_req_sel = (|w_req_hi) ? w_req_hi : i_req;
   end

   always_comb begin
      o_grant     = '0;
      o_grant_idx = '0;
      o_any       = 1'b0;
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
         if (!o_any && w_req_sel[i]) begin
            o_grant[i]  = 1'b1;
            o_grant_idx = IDX_W'(i);
            o_any       = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ptr <= '0;
      end else if (i_update_en && o_any) begin
         r_ptr <= (o_grant_idx == IDX_W'(NUM_REQUESTERS - 1)) ? '0 : o_grant_idx + 1'b1;
      end
   end

endmodule

// File: rtl/io_interconnect.sv
// Uncached IO interconnect: round-robin arbitration of core load/store requests onto a
// single IO device port, with io_ready handshake, timeout abort and tagged responses.
module io_interconnect
   import io_interconnect_pkg::*;
#(
   parameter int  NUM_REQUESTERS  = 4,
   parameter int  ADDR_WIDTH      = 32,
   parameter int  DATA_WIDTH      = 32,
   parameter int  THREAD_ID_WIDTH = 2,
   parameter int  TIMEOUT_CYCLES  = 1024,
   localparam int CORE_ID_WIDTH   = core_id_width(NUM_REQUESTERS)
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [NUM_REQUESTERS-1:0]             req_valid,
   input  logic [NUM_REQUESTERS-1:0]             req_store,
   input  logic [NUM_REQUESTERS*ADDR_WIDTH-1:0]  req_address,
   input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0]  req_write_data,
   input  logic [NUM_REQUESTERS*THREAD_ID_WIDTH-1:0] req_thread,
   output logic [NUM_REQUESTERS-1:0]             req_ready,
   output logic                                  rsp_valid,
   output logic [CORE_ID_WIDTH-1:0]              rsp_core,
   output logic [THREAD_ID_WIDTH-1:0]            rsp_thread,
   output logic [DATA_WIDTH-1:0]                 rsp_read_data,
   output logic                                  rsp_error,
   output logic                                  io_write_en,
   output logic                                  io_read_en,
   output logic [ADDR_WIDTH-1:0]                 io_address,
   output logic [DATA_WIDTH-1:0]                 io_write_data,
   input  logic [DATA_WIDTH-1:0]                 io_read_data,
   input  logic                                  io_ready
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

   io_state_t                     r_state, w_state_next;
   logic [NUM_REQUESTERS-1:0]     w_grant;
   logic [CORE_ID_WIDTH-1:0]      w_grant_idx;
   logic                          w_any, w_accept, w_timeout;
   logic                          w_sel_store;
   logic [ADDR_WIDTH-1:0]         w_sel_address;
   logic [DATA_WIDTH-1:0]         w_sel_wdata;
   logic [THREAD_ID_WIDTH-1:0]    w_sel_thread;

   logic                          r_store, r_error;
   logic [ADDR_WIDTH-1:0]         r_address;
   logic [DATA_WIDTH-1:0]         r_wdata, r_rdata;
   logic [THREAD_ID_WIDTH-1:0]    r_thread;
   logic [CORE_ID_WIDTH-1:0]      r_core;
   logic [CNT_W-1:0]              r_count;

   rr_arbiter #(.NUM_REQUESTERS(NUM_REQUESTERS)) u_arbiter (
      .clk         (clk),
      .reset       (reset),
      .i_req       (req_valid),
      .i_update_en (w_accept),
      .o_grant     (w_grant),
      .o_grant_idx (w_grant_idx),
      .o_any       (w_any)
   );

   // Reset gates acceptance so req_ready stays low while reset is held.
   assign w_accept  = (r_state == IDLE) && w_any && reset;
   assign w_timeout = (r_count == CNT_W'(TIMEOUT_CYCLES - 1)) && !io_ready;

   // One-hot AND-OR select of the granted core's request fields.
   always_comb begin
      w_sel_store   = 1'b0;
      w_sel_address = '0;
      w_sel_wdata   = '0;
      w_sel_thread  = '0;
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
         w_sel_store   |= w_grant[i] & req_store[i];
         w_sel_address |= {ADDR_WIDTH{w_grant[i]}} & req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
         w_sel_wdata   |= {DATA_WIDTH{w_grant[i]}} & req_write_data[i*DATA_WIDTH +: DATA_WIDTH];
         w_sel_thread  |= {THREAD_ID_WIDTH{w_grant[i]}} & req_thread[i*THREAD_ID_WIDTH +: THREAD_ID_WIDTH];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE:    if (w_accept) w_state_next = ISSUE;
         ISSUE:   if (io_ready || w_timeout) w_state_next = RESPOND;
         RESPOND: w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_store   <= 1'b0;
         r_error   <= 1'b0;
         r_address <= '0;
         r_wdata   <= '0;
         r_rdata   <= '0;
         r_thread  <= '0;
         r_core    <= '0;
         r_count   <= '0;
      end else begin
         unique case (r_state)
            IDLE: if (w_accept) begin
               r_store   <= w_sel_store;
               r_address <= w_sel_address;
               r_wdata   <= w_sel_wdata;
               r_thread  <= w_sel_thread;
               r_core    <= w_grant_idx;
               r_rdata   <= '0;
            end
            ISSUE: begin
               if (io_ready)       r_rdata <= r_store ? '0 : io_read_data;
               else if (w_timeout) r_error <= 1'b1;
               else                r_count <= r_count + 1'b1;
            end
            RESPOND: begin
               r_count <= '0;
               r_error <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      req_ready     = '0;
      rsp_valid     = 1'b0;
      rsp_core      = '0;
      rsp_thread    = '0;
      rsp_read_data = '0;
      rsp_error     = 1'b0;
      io_write_en   = 1'b0;
      io_read_en    = 1'b0;
      io_address    = '0;
      io_write_data = '0;
      unique case (r_state)
         IDLE: if (w_accept) req_ready = w_grant;
         ISSUE: begin
            io_write_en   = r_store;
            io_read_en    = !r_store;
            io_address    = r_address;
            io_write_data = r_wdata;
         end
         RESPOND: begin
            rsp_valid     = 1'b1;
            rsp_core      = r_core;
            rsp_thread    = r_thread;
            rsp_read_data = r_rdata;
            rsp_error     = r_error;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_io_interconnect.sv
// Randomised scoreboard bench for io_interconnect against a round-robin transaction model.
module tb_io_interconnect;
   import io_interconnect_pkg::*;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TW = 2;
   localparam int TO = 8;
   localparam int CW = core_id_width(N);

   logic              clk   = 1'b0;
   logic              reset = 1'b0;
   logic [N-1:0]      req_valid, req_store;
   logic [N*AW-1:0]   req_address;
   logic [N*DW-1:0]   req_write_data;
   logic [N*TW-1:0]   req_thread;
   logic [N-1:0]      req_ready;
   logic              rsp_valid, rsp_error, io_write_en, io_read_en, io_ready;
   logic [CW-1:0]     rsp_core;
   logic [TW-1:0]     rsp_thread;
   logic [DW-1:0]     rsp_read_data, io_write_data, io_read_data;
   logic [AW-1:0]     io_address;

   io_interconnect #(
      .NUM_REQUESTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .THREAD_ID_WIDTH(TW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_store(req_store), .req_address(req_address),
      .req_write_data(req_write_data), .req_thread(req_thread), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_core(rsp_core), .rsp_thread(rsp_thread),
      .rsp_read_data(rsp_read_data), .rsp_error(rsp_error),
      .io_write_en(io_write_en), .io_read_en(io_read_en), .io_address(io_address),
      .io_write_data(io_write_data), .io_read_data(io_read_data), .io_ready(io_ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Pending requests per core as seen by the cores.
   bit            pend[N];
   bit            st[N];
   logic [AW-1:0] ad[N];
   logic [DW-1:0] wd[N];
   logic [TW-1:0] th[N];

   typedef struct {
      int            core;
      int            thread;
      logic [DW-1:0] data;
      bit            err;
      int            cyc;
   } rsp_t;
   rsp_t exp_q[$];

   int            ptr, busy, busy_cycles, grant_cyc, dev_c;
   int            cur_w, cur_n;
   bit            cur_store;
   logic [AW-1:0] cur_addr;
   logic [DW-1:0] cur_wdata, cur_data;
   int            gen_mode;  // 0 directed only, 1 all cores always requesting, 2 random
   int            w_q[$];
   logic [DW-1:0] d_q[$];
   bit            release_rst;

   function automatic int rr_pick();
      for (int k = 0; k < N; k++) begin
         int i = (ptr + k) % N;
         if (pend[i]) return i;
      end
      return -1;
   endfunction

   task automatic new_req(input int i);
      pend[i] = 1'b1;
      st[i]   = 1'($urandom_range(0, 1));
      ad[i]   = $urandom;
      wd[i]   = $urandom;
      th[i]   = TW'($urandom_range(0, 3));
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req_valid[i]                = pend[i];
         req_store[i]                = st[i];
         req_address[i*AW +: AW]     = ad[i];
         req_write_data[i*DW +: DW]  = wd[i];
         req_thread[i*TW +: TW]      = th[i];
      end
   endtask

   task automatic check_outputs_zero();
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_core", rsp_core, 0);
      chk("rst_rsp_thread", rsp_thread, 0);
      chk("rst_rsp_data", rsp_read_data, 0);
      chk("rst_rsp_error", rsp_error, 0);
      chk("rst_io_we", io_write_en, 0);
      chk("rst_io_re", io_read_en, 0);
      chk("rst_io_addr", io_address, 0);
      chk("rst_io_wdata", io_write_data, 0);
   endtask

   // One clock: drive requests just after the edge, act as device/arbiter model at negedge.
   task automatic step();
      int            g;
      logic [N-1:0]  e;
      rsp_t          r;
      @(posedge clk);
      #1;
      drive();
      if (release_rst) begin
         reset       = 1'b1;
         release_rst = 1'b0;
      end
      @(negedge clk);
      if (io_write_en || io_read_en) begin
         chk("enable_while_busy", busy != 0, 1);
         if (dev_c == 0) begin
            chk("issue_latency", cyc, grant_cyc + 1);
            chk("issue_we", io_write_en, cur_store);
            chk("issue_re", io_read_en, !cur_store);
            chk("issue_addr", io_address, cur_addr);
            chk("issue_wdata", io_write_data, cur_wdata);
         end
         chk("issue_len", dev_c < cur_n, 1);
         io_ready     = (dev_c == cur_w);
         io_read_data = io_ready ? cur_data : DW'($urandom);
         dev_c++;
      end else begin
         io_ready     = 1'($urandom_range(0, 1));
         io_read_data = $urandom;
      end
      if (busy == 0) begin
         g = rr_pick();
         e = '0;
         if (g >= 0) e[g] = 1'b1;
         chk("grant", req_ready, e);
         if (g >= 0) begin
            cur_store = st[g];
            cur_addr  = ad[g];
            cur_wdata = wd[g];
            if (w_q.size() > 0) cur_w = w_q.pop_front();
            else cur_w = ($urandom_range(0, 4) == 0) ? $urandom_range(0, TO + 2) : $urandom_range(0, 2);
            if (d_q.size() > 0) cur_data = d_q.pop_front();
            else cur_data = $urandom;
            cur_n       = (cur_w < TO) ? cur_w + 1 : TO;
            r.core      = g;
            r.thread    = int'(th[g]);
            r.err       = (cur_w >= TO);
            r.data      = (cur_store || r.err) ? '0 : cur_data;
            r.cyc       = cyc + 1 + cur_n;
            exp_q.push_back(r);
            grant_cyc   = cyc;
            ptr         = (g + 1) % N;
            busy        = 1;
            busy_cycles = 0;
            dev_c       = 0;
            pend[g]     = 1'b0;
            if (gen_mode == 1) new_req(g);
         end
      end else begin
         chk("no_grant_busy", req_ready, 0);
         if (rsp_valid) busy = 0;
         busy_cycles++;
         if (busy_cycles > TO + 4) begin
            n_checks++;
            n_fail++;
            $display("FAIL watchdog: no response %0d cycles after grant", busy_cycles);
            busy = 0;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!pend[i] && (gen_mode == 1 || (gen_mode == 2 && $urandom_range(0, 3) == 0)))
            new_req(i);
      end
   endtask

   // Scoreboard monitor: every response must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rsp_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rsp: core %0d with nothing outstanding", rsp_core);
         end else begin
            rsp_t e;
            e = exp_q.pop_front();
            $display("rsp core=%0d thread=%0d data=%08h err=%0b cycle=%0d",
                     rsp_core, rsp_thread, rsp_read_data, rsp_error, cyc);
            chk("rsp_core", rsp_core, e.core);
            chk("rsp_thread", rsp_thread, e.thread);
            chk("rsp_data", rsp_read_data, e.data);
            chk("rsp_error", rsp_error, e.err);
            chk("rsp_cycle", cyc, e.cyc);
         end
      end
   end

   initial begin
      io_ready     = 1'b0;
      io_read_data = '0;
      ptr = 0; busy = 0; busy_cycles = 0; grant_cyc = 0; dev_c = 0;
      cur_w = 0; cur_n = 1; gen_mode = 0; release_rst = 1'b0;
      for (int i = 0; i < N; i++) new_req(i);
      drive();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outputs_zero();
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      release_rst = 1'b1;

      // Directed: core 2 read, zero-wait device returning DEADBEEF.
      st[2] = 1'b0; ad[2] = 32'hFFFF_0004; th[2] = 2'd1; pend[2] = 1'b1;
      w_q.push_back(0);
      d_q.push_back(32'hDEAD_BEEF);
      repeat (6) step();

      // All cores requesting continuously against a zero-wait device.
      for (int k = 0; k < 8; k++) w_q.push_back(0);
      gen_mode = 1;
      for (int i = 0; i < N; i++) if (!pend[i]) new_req(i);
      repeat (24) step();
      gen_mode = 0;
      w_q.delete();
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      for (int k = 0; k < 40 && busy != 0; k++) step();

      // Core 1 store with five wait cycles.
      st[1] = 1'b1; ad[1] = 32'h0000_0100; wd[1] = 32'h1234_5678; th[1] = 2'd3; pend[1] = 1'b1;
      w_q.push_back(5);
      repeat (10) step();

      // Timeout, timeout-coincident success, then a normal request.
      w_q.push_back(TO + 3);
      w_q.push_back(TO - 1);
      w_q.push_back(0);
      new_req(3); st[3] = 1'b0;
      new_req(0); st[0] = 1'b0;
      new_req(2);
      repeat (3 * (TO + 4)) step();

      // Random traffic.
      gen_mode = 2;
      repeat (1500) step();

      // Reset asserted while a transaction is issuing.
      gen_mode = 1;
      for (int k = 0; k < 50 && !(io_write_en || io_read_en); k++) step();
      chk("reset_phase_in_issue", io_write_en || io_read_en, 1);
      reset = 1'b0;
      io_ready = 1'b0;
      #1;
      check_outputs_zero();
      exp_q.delete();
      w_q.delete();
      d_q.delete();
      busy = 0; ptr = 0; dev_c = 0;
      for (int i = 0; i < N; i++) new_req(i);
      drive();
      repeat (2) @(negedge clk);
      check_outputs_zero();
      release_rst = 1'b1;
      gen_mode = 2;
      repeat (40) step();

      gen_mode = 0;
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      for (int k = 0; k < 40 && busy != 0; k++) step();
      repeat (2) step();
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
